// File: rtl/audio_i2s_pkg.sv
// Shared audio/I2S defaults, PCM pair type and frame slot-index constants.
package audio_i2s_pkg;
    localparam int DATA_W      = 24;
    localparam int SLOT_W      = 32;
    localparam int FRAME_BITS  = 2 * SLOT_W;
    localparam int LEFT_MSB_K  = 1;
    localparam int RIGHT_MSB_K = SLOT_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } pcm_pair_t;
endpackage

// File: rtl/pcm_pair_fifo.sv
// Two-entry PCM pair buffer with occupancy count and synchronous flush.
module pcm_pair_fifo #(
    parameter int W = 2 * audio_i2s_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count,
    output logic [1:0]   count_nxt
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_pop;
    logic         wr_ptr;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // A pop against an empty buffer is ignored; the parent loads zeros instead.
        do_pop   = pop && (count_q != 2'd0);
        wr_ptr   = rd_ptr_q ^ (count_q == 2'd1);
        if (flush) begin
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push)
                mem_d[wr_ptr] = push_data;
            if (do_pop)
                rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign count_nxt = count_d;
endmodule

// File: rtl/i2s_frame_transmitter.sv
// I2S (Philips) master transmitter: bclk/lrclk generation and MSB-first serialisation
// of buffered stereo PCM pairs, one pair per 2*SLOT_W-bit frame.
module i2s_frame_transmitter
    import audio_i2s_pkg::*;
#(
    parameter int DATA_W   = audio_i2s_pkg::DATA_W,
    parameter int SLOT_W   = audio_i2s_pkg::SLOT_W,
    parameter int BCLK_DIV = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] l_data,
    input  logic [DATA_W-1:0] r_data,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              frame_start,
    output logic              underflow,
    input  logic              underflow_clr
);
    localparam int FRAME_N = 2 * SLOT_W;
    localparam int K_W     = $clog2(FRAME_N);
    localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(FRAME_N - 1);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [K_W-1:0]    k_q, k_d, k_new;
    logic              bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
    logic              frame_start_q, frame_start_d, underflow_q, underflow_d;
    logic              s_ready_q, s_ready_d;
    logic [DATA_W-1:0] cur_l_q, cur_l_d, cur_r_q, cur_r_d, word;
    logic              uf_set, fifo_push, fifo_pop, fifo_flush;
    logic [2*DATA_W-1:0] fifo_head;
    logic [1:0]        fifo_count, fifo_count_nxt;
    int                kk;

    pcm_pair_fifo #(.W(2 * DATA_W)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data ({l_data, r_data}),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .count_nxt (fifo_count_nxt)
    );

    always_comb begin
        div_d         = div_q;
        bclk_d        = bclk_q;
        k_d           = k_q;
        k_new         = k_q;
        lrclk_d       = lrclk_q;
        sdata_d       = sdata_q;
        cur_l_d       = cur_l_q;
        cur_r_d       = cur_r_q;
        frame_start_d = 1'b0;
        uf_set        = 1'b0;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        fifo_flush    = 1'b0;
        word          = '0;
        kk            = 0;
        if (!enable) begin
            div_d      = '0;
            bclk_d     = 1'b0;
            k_d        = K_LAST;
            lrclk_d    = 1'b1;
            sdata_d    = 1'b0;
            cur_l_d    = '0;
            cur_r_d    = '0;
            fifo_flush = 1'b1;
        end else begin
            fifo_push = s_valid && s_ready_q;
            if (int'(div_q) == BCLK_DIV - 1) begin
                div_d  = '0;
                bclk_d = ~bclk_q;
                // Falling-edge cycle: everything on the serial side moves here.
                if (bclk_q) begin
                    k_new   = (k_q == K_LAST) ? '0 : k_q + 1'b1;
                    k_d     = k_new;
                    kk      = int'(k_new);
                    lrclk_d = (kk >= SLOT_W);
                    if (kk >= LEFT_MSB_K && kk <= DATA_W) begin
                        word    = cur_l_q >> (DATA_W - kk);
                        sdata_d = word[0];
                    end else if (kk >= SLOT_W + 1 && kk <= SLOT_W + DATA_W) begin
                        word    = cur_r_q >> (SLOT_W + DATA_W - kk);
                        sdata_d = word[0];
                    end else begin
                        sdata_d = 1'b0;
                    end
                    if (kk == 0) begin
                        frame_start_d = 1'b1;
                        fifo_pop      = 1'b1;
                        if (fifo_count == 2'd0) begin
                            uf_set  = 1'b1;
                            cur_l_d = '0;
                            cur_r_d = '0;
                        end else begin
                            {cur_l_d, cur_r_d} = fifo_head;
                        end
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
        underflow_d = uf_set ? 1'b1 : (underflow_clr ? 1'b0 : underflow_q);
        s_ready_d   = enable && (fifo_count_nxt < 2'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            bclk_q        <= 1'b0;
            k_q           <= K_LAST;
            lrclk_q       <= 1'b1;
            sdata_q       <= 1'b0;
            cur_l_q       <= '0;
            cur_r_q       <= '0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            s_ready_q     <= 1'b0;
        end else begin
            div_q         <= div_d;
            bclk_q        <= bclk_d;
            k_q           <= k_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            cur_l_q       <= cur_l_d;
            cur_r_q       <= cur_r_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
            s_ready_q     <= s_ready_d;
        end
    end

    assign bclk        = bclk_q;
    assign lrclk       = lrclk_q;
    assign sdata       = sdata_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
    assign s_ready     = s_ready_q;
endmodule

// File: tb/tb_i2s_frame_transmitter.sv
// Randomized bench for i2s_frame_transmitter against a frame-arithmetic reference model.
module tb_i2s_frame_transmitter;
    import audio_i2s_pkg::*;

    localparam int D = 2;
    localparam int S = SLOT_W;
    localparam int W = DATA_W;

    logic         clk = 1'b0;
    logic         reset, enable, s_valid, underflow_clr;
    logic [W-1:0] l_data, r_data;
    logic         s_ready, bclk, lrclk, sdata, frame_start, underflow;

    i2s_frame_transmitter #(.DATA_W(W), .SLOT_W(S), .BCLK_DIV(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .l_data        (l_data),
        .r_data        (r_data),
        .bclk          (bclk),
        .lrclk         (lrclk),
        .sdata         (sdata),
        .frame_start   (frame_start),
        .underflow     (underflow),
        .underflow_clr (underflow_clr)
    );

    always #5 clk = ~clk;

    // Model: t = enabled edges seen minus one (-1 when idle); everything else follows from t.
    int        t = -1;
    pcm_pair_t mq[$];
    pcm_pair_t pend[$];
    pcm_pair_t cur;
    bit        uf = 1'b0, m_ready = 1'b0, cap_on = 1'b0;
    int        vprob = 100;
    int        n_chk = 0, n_pass = 0;
    logic [W-1:0] rx_l, rx_r;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, got, exp, t, $time);
    endtask

    function automatic int n_fall(input int tt);
        if (tt < 0) return 0;
        return ((tt + 1) / D) / 2;
    endfunction

    function automatic int k_of(input int tt);
        return (2 * S - 1 + n_fall(tt)) % (2 * S);
    endfunction

    function automatic bit is_fall(input int tt);
        return tt >= 0 && ((tt + 1) % D == 0) && (((tt + 1) / D) % 2 == 0);
    endfunction

    function automatic bit is_load(input int tt);
        return is_fall(tt) && k_of(tt) == 0;
    endfunction

    function automatic pcm_pair_t mk(input logic [W-1:0] l, input logic [W-1:0] r);
        pcm_pair_t p;
        p.l = l;
        p.r = r;
        return p;
    endfunction

    function automatic pcm_pair_t rand_pair();
        return mk(W'($urandom), W'($urandom));
    endfunction

    task automatic model_edge();
        bit push, set;
        push = s_valid && m_ready && enable && !reset;
        set  = 1'b0;
        if (reset) begin
            t = -1; mq.delete(); cur = '0; uf = 1'b0; m_ready = 1'b0;
        end else begin
            if (!enable) begin
                t = -1; mq.delete(); cur = '0; m_ready = 1'b0;
            end else begin
                t++;
                if (is_load(t)) begin
                    if (mq.size() == 0) begin cur = '0; set = 1'b1; end
                    else cur = mq.pop_front();
                end
                if (push) begin
                    mq.push_back(mk(l_data, r_data));
                    void'(pend.pop_front());
                end
                m_ready = (mq.size() < 2);
            end
            if (set) uf = 1'b1;
            else if (underflow_clr) uf = 1'b0;
        end
    endtask

    function automatic int exp_sdata();
        int k;
        int lw, rw;
        k  = k_of(t);
        lw = int'(cur.l);
        rw = int'(cur.r);
        if (t < 0) return 0;
        if (k >= 1 && k <= W) return (lw >> (W - k)) & 1;
        if (k >= S + 1 && k <= S + W) return (rw >> (S + W - k)) & 1;
        return 0;
    endfunction

    task automatic check_all();
        chk("bclk",        int'(bclk),        (t < 0) ? 0 : ((t + 1) / D) % 2);
        chk("lrclk",       int'(lrclk),       (t < 0) ? 1 : int'(k_of(t) >= S));
        chk("sdata",       int'(sdata),       exp_sdata());
        chk("frame_start", int'(frame_start), int'(is_load(t)));
        chk("underflow",   int'(underflow),   int'(uf));
        chk("s_ready",     int'(s_ready),     int'(m_ready));
    endtask

    task automatic tick();
        if (pend.size() > 0 && $urandom_range(99) < vprob) begin
            s_valid = 1'b1; l_data = pend[0].l; r_data = pend[0].r;
        end else begin
            s_valid = 1'b0; l_data = W'($urandom); r_data = W'($urandom);
        end
        model_edge();
        @(negedge clk);
        check_all();
        if (cap_on && is_fall(t) && n_fall(t) >= 1 && n_fall(t) <= 2 * S) begin
            if (k_of(t) >= 1 && k_of(t) <= W) rx_l = {rx_l[W-2:0], sdata};
            if (k_of(t) >= S + 1 && k_of(t) <= S + W) rx_r = {rx_r[W-2:0], sdata};
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; enable = 1'b0; s_valid = 1'b0; underflow_clr = 1'b0;
        l_data = '0; r_data = '0; cur = '0; rx_l = '0; rx_r = '0;
        @(negedge clk);
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Idle-data run: zeros on sdata, underflow from the first frame.
        enable = 1'b1;
        repeat (600) tick();
        chk("uf_idle", int'(underflow), 1);
        underflow_clr = 1'b1; tick(); underflow_clr = 1'b0; tick();
        chk("uf_clr", int'(underflow), 0);
        n = 0;
        while (!is_load(t + 1) && n < 1000) begin tick(); n++; end
        underflow_clr = 1'b1; tick(); underflow_clr = 1'b0;
        chk("uf_set_wins", int'(underflow), 1);
        underflow_clr = 1'b1; tick(); underflow_clr = 1'b0;
        chk("uf_clr_late", int'(underflow), 0);

        // Known pattern, decoded back from the serial line.
        enable = 1'b0; repeat (2) tick();
        pend.push_back(mk(24'h800001, 24'h7FFFFE));
        enable = 1'b1; cap_on = 1'b1;
        repeat (300) tick();
        cap_on = 1'b0;
        chk("loop_l", int'(rx_l), 32'h800001);
        chk("loop_r", int'(rx_r), 32'h7FFFFE);

        // Three pairs back-to-back.
        enable = 1'b0; tick();
        repeat (3) pend.push_back(rand_pair());
        enable = 1'b1;
        repeat (1024) tick();
        chk("b2b_drained", pend.size(), 0);

        // Abort mid-frame at k=40, then restart.
        repeat (6) pend.push_back(rand_pair());
        n = 0;
        while (k_of(t) != 40 && n < 2000) begin tick(); n++; end
        enable = 1'b0; tick();
        chk("abort_bclk",    int'(bclk), 0);
        chk("abort_lrclk",   int'(lrclk), 1);
        chk("abort_sdata",   int'(sdata), 0);
        chk("abort_s_ready", int'(s_ready), 0);
        chk("abort_uf_kept", int'(underflow), int'(uf));
        enable = 1'b1; n = 0;
        do begin tick(); n++; end while (frame_start !== 1'b1 && n < 100);
        chk("restart_lat", n, 2 * D);
        repeat (600) tick();

        // Reset mid-frame at k=10 with a full buffer and underflow set.
        pend.delete();
        enable = 1'b0; tick(); enable = 1'b1;
        repeat (2 * D + 2) tick();
        repeat (4) pend.push_back(rand_pair());
        n = 0;
        while (k_of(t) != 10 && n < 2000) begin tick(); n++; end
        chk("pre_rst_uf", int'(underflow), 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_bclk",    int'(bclk), 0);
        chk("rst_lrclk",   int'(lrclk), 1);
        chk("rst_sdata",   int'(sdata), 0);
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_fs",      int'(frame_start), 0);
        chk("rst_uf",      int'(underflow), 0);

        // Random traffic with occasional clears and single-cycle enable drops.
        vprob = 50;
        for (int i = 0; i < 1500; i++) begin
            if (pend.size() < 2) pend.push_back(rand_pair());
            underflow_clr = ($urandom_range(49) == 0);
            enable        = ($urandom_range(399) != 0);
            tick();
        end
        underflow_clr = 1'b0; enable = 1'b1;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
